// File: rtl/mat_pkg.sv
// Shared packing definitions for 3x3 matrix stream blocks.
// Anything that packs or unpacks the matrix word imports this.
package mat_pkg;

    localparam int N     = 3;
    localparam int W     = 4;
    localparam int MAT_W = N * N * W;
    localparam int IDX_W = $clog2(N * N);
    localparam int RC_W  = $clog2(N);
    localparam int OFF_W = $clog2(MAT_W);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    // Element (0,0) sits in the MSBs; row-major toward the LSBs.
    function automatic logic [OFF_W-1:0] slot_lsb(
        input logic [RC_W-1:0] i,
        input logic [RC_W-1:0] j
    );
        int k;
        k = (N * N - 1 - (int'(i) * N + int'(j))) * W;
        return OFF_W'(k);
    endfunction

endpackage

// File: rtl/mat_rc_counter.sv
// Row/column wrap counter walking an N x N matrix in row-major order.
// last flags the final slot; inc there wraps back to (0,0).
module mat_rc_counter
    import mat_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    output logic [RC_W-1:0] row,
    output logic [RC_W-1:0] col,
    output logic            last
);

    localparam logic [RC_W-1:0] MAX = RC_W'(N - 1);

    logic [RC_W-1:0] row_q;
    logic [RC_W-1:0] col_q;
    logic [RC_W-1:0] row_d;
    logic [RC_W-1:0] col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == MAX) begin
                col_d = '0;
                row_d = (row_q == MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/mat_stream_packer.sv
// Packs a row-major element stream into one N*N*W matrix word,
// with end-of-matrix framing checks and a synchronous abort.
module mat_stream_packer
    import mat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAT_W-1:0] out_mat,
    output logic [RC_W-1:0]  row,
    output logic [RC_W-1:0]  col,
    output logic             frame_err
);

    state_t           state_q;
    logic [MAT_W-1:0] buf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             frame_err_q;

    logic accept;
    logic xfer;
    logic take;
    logic early;
    logic last_slot;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;
    assign take   = accept && !clr;
    assign early  = take && in_last && !last_slot;

    mat_rc_counter u_rc (
        .clk  (clk),
        .rst  (rst),
        .inc  (take && !early),
        .clr  (clr || early),
        .row  (row),
        .col  (col),
        .last (last_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (clr) begin
            state_q     <= FILL;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (early) begin
                        buf_q       <= '0;
                        frame_err_q <= 1'b1;
                    end else if (accept) begin
                        buf_q[slot_lsb(row, col) +: W] <= in_data;
                        if (last_slot) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            frame_err_q <= !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state_q     <= FILL;
                        buf_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mat   = buf_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mat_stream_packer.sv
// Randomized and directed bench for mat_stream_packer.
// A queue-free slot model predicts every output each cycle.
module tb_mat_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_mat;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        frame_err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int vcyc[2];

    mat_stream_packer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mat   (out_mat),
        .row       (row),
        .col       (col),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Reference: slots filled so far, count, and handshake flags.
    logic [3:0] m_el[9];
    int         m_cnt;
    logic       m_rdy;
    logic       m_vld;
    logic       m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy <= 1'b0;
            m_vld <= 1'b0;
            m_err <= 1'b0;
            m_cnt <= 0;
            for (int k = 0; k < 9; k++) m_el[k] <= '0;
        end else begin
            m_err <= 1'b0;
            if (clr) begin
                m_cnt <= 0;
                m_vld <= 1'b0;
                m_rdy <= 1'b1;
                for (int k = 0; k < 9; k++) m_el[k] <= '0;
            end else if (m_vld) begin
                if (out_ready) begin
                    m_vld <= 1'b0;
                    m_rdy <= 1'b1;
                    for (int k = 0; k < 9; k++) m_el[k] <= '0;
                end
            end else begin
                m_rdy <= 1'b1;
                if (in_valid && m_rdy) begin
                    if (in_last && m_cnt < 8) begin
                        m_err <= 1'b1;
                        m_cnt <= 0;
                        for (int k = 0; k < 9; k++) m_el[k] <= '0;
                    end else begin
                        m_el[m_cnt] <= in_data;
                        if (m_cnt == 8) begin
                            m_cnt <= 0;
                            m_vld <= 1'b1;
                            m_rdy <= 1'b0;
                            m_err <= !in_last;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [35:0] packed_mat();
        logic [35:0] m;
        m = '0;
        for (int k = 0; k < 9; k++) m = {m[31:0], m_el[k]};
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("out_valid", 64'(out_valid), 64'(m_vld));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("row", 64'(row), 64'(m_cnt / 3));
        check("col", 64'(col), 64'(m_cnt % 3));
        check("out_mat", 64'(out_mat), 64'(packed_mat()));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (out_valid && vcnt < 2) begin
            vcyc[vcnt] = cyc;
            vcnt++;
        end
        compare_all();
    endtask

    task automatic send(input logic [3:0] v, input logic lst);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = lst;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            acc = m_rdy;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_mat", 64'(out_mat), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready), 64'(1));

        // 1..9 framed, consumer ready
        for (int k = 1; k <= 9; k++) send(4'(k), k == 9);
        check("basic_valid", 64'(out_valid), 64'(1));
        check("basic_mat", 64'(out_mat), 64'h123456789);
        check("basic_err", 64'(frame_err), 64'(0));
        tick();

        // consumer stalls 5 cycles
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) send(4'(k), k == 9);
        idle(5);
        check("stall_mat", 64'(out_mat), 64'h123456789);
        check("stall_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        check("stall_release", 64'(in_ready), 64'(1));

        // early end then a clean 9..1
        for (int k = 1; k <= 4; k++) send(4'(k), k == 4);
        check("early_err", 64'(frame_err), 64'(1));
        check("early_valid", 64'(out_valid), 64'(0));
        for (int k = 9; k >= 1; k--) send(4'(k), k == 1);
        check("early_next_mat", 64'(out_mat), 64'h987654321);
        tick();

        // missing end marker still delivers
        for (int k = 0; k < 9; k++) send(4'hF, 1'b0);
        check("miss_err", 64'(frame_err), 64'(1));
        check("miss_mat", 64'(out_mat), 64'hFFFFFFFFF);
        tick();

        // abort with a concurrent element
        for (int k = 1; k <= 5; k++) send(4'(k), 1'b0);
        in_valid = 1'b1;
        in_data = 4'h6;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_row", 64'(row), 64'(0));
        check("clr_col", 64'(col), 64'(0));
        check("clr_mat", 64'(out_mat), 64'(0));

        // async reset while holding
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) send(4'(k), k == 9);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_mat", 64'(out_mat), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("arst_ready", 64'(in_ready), 64'(1));

        // back-to-back throughput
        vcnt = 0;
        for (int k = 0; k < 18; k++) send(4'(k % 16), (k % 9) == 8);
        idle(2);
        check("b2b_count", 64'(vcnt), 64'(2));
        check("b2b_gap", 64'(vcyc[1] - vcyc[0]), 64'(10));

        // random traffic
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            in_last   = (m_cnt == 8) ? ($urandom_range(0, 5) != 0)
                                     : ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 40) == 0);
            tick();
        end
        clr = 1'b0;
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mat_stream_packer.md
Name: mat_stream_packer

Overview:
- Writer-side companion to the team's combinational 3x3 transpose/multiply block, which consumes one packed row-major matrix word (4-bit elements, 36 bits).
- Accepts matrix elements one per cycle over a valid/ready stream.
- Assembles them into that packed word and presents the word on a valid/ready output for the multiplier stage.
- Checks framing with an end-of-matrix marker and supports a synchronous abort.

Parameters:
- N, 3, matrix dimension (N x N).
- W, 4, element width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort; discards the partial or held matrix.
- in_valid  in  1  element present.
- in_ready  out  1  packer can accept an element.
- in_data  in  W  element value, row-major order.
- in_last  in  1  marks the final element of a matrix.
- out_valid  out  1  packed matrix available.
- out_ready  in  1  consumer accepts the matrix.
- out_mat  out  N*N*W  packed matrix; element (i,j) at bits [(N*N-1-(i*N+j))*W +: W], so (0,0) is the MSBs.
- row  out  ceil(log2 N)  row index of the next element to be written.
- col  out  ceil(log2 N)  column index of the next element to be written.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- One clock domain. rst is asynchronous, active-high.
- Reset values: state=FILL, idx=0, row=0, col=0, buffer=0, out_mat=0, in_ready=0, out_valid=0, frame_err=0.
- in_ready is registered: it goes to 1 on the first clk edge after rst deasserts.
- An element is accepted on a cycle where in_valid && in_ready.
- An output transfer occurs on a cycle where out_valid && out_ready.
- Internal element counter idx runs 0..N*N-1. row = idx / N and col = idx % N, maintained as a row/col counter pair (col wraps at N-1, then row increments).
- State FILL:
  - in_ready=1, out_valid=0.
  - On accept, in_data is written to slot idx.
  - If idx<N*N-1, idx increments.
  - If idx==N*N-1, the element is stored, idx wraps to 0, and state goes to HOLD.
  - In HOLD, out_valid=1 and in_ready=0 starting the next cycle. Latency from last accept to out_valid is 1 cycle.
- State HOLD:
  - out_mat stays stable while out_valid=1.
  - On transfer: buffer is zeroed, state goes to FILL, out_valid=0, and in_ready=1 the next cycle. Maximum throughput is one matrix per N*N+1 cycles.
- Framing rules:
  - in_last accepted with idx<N*N-1 (early end): frame_err pulses the next cycle, the partial matrix is discarded (buffer zeroed, idx=0), and state stays FILL.
  - Final element accepted with in_last=0 (missing end): frame_err pulses, and the matrix is still delivered normally.
- clr:
  - Highest priority below rst: state=FILL, idx=0, buffer=0, out_valid=0, in_ready=1 next cycle.
  - An element accepted in the same cycle as clr is dropped.
  - A transfer occurring in the same cycle as clr counts as completed.
- Back-to-back: in FILL, consecutive accepts write consecutive slots with no bubbles.
- Reset asserted mid-fill or in HOLD returns all state to reset values immediately (asynchronously).
- Arithmetic: no arithmetic on data. Elements are stored verbatim at W bits; nothing is widened or truncated.

Decomposition:
- Shared package mat_pkg holds:
  - N and W defaults;
  - MAT_W = N*N*W;
  - IDX_W = ceil(log2(N*N));
  - the state enum {FILL, HOLD};
  - a slot-offset function returning the LSB position of element (i,j).
- The multiplier block and any future unpacker should import the same package so packing stays consistent.
- The row/col wrap counter is a natural single sub-module, mat_rc_counter (inc, clr, row, col, last flag).

Test Plan:
- Reset, then stream elements 1..9 with in_last on the 9th and out_ready=1 → out_valid 1 cycle after 9th accept; out_mat=36'h123456789; frame_err never asserts.
- Same stream with out_ready=0 for 5 cycles → out_mat held stable; in_ready=0 throughout; transfer on the 6th cycle; in_ready=1 the next cycle.
- Stream 1..4 with in_last on the 4th → frame_err pulse; no out_valid; next nine elements 9..1 produce out_mat=36'h987654321.
- Stream 9 elements of value 4'hF with no in_last → frame_err pulse; out_mat=36'hFFFFFFFFF still delivered.
- Accept 5 elements, assert clr on the 6th with in_valid=1 → 6th dropped; row=0, col=0; buffer zero. Then assert rst mid-HOLD → out_valid=0 and out_mat=0 immediately, in_ready=1 after the first edge following deassertion.
- Two matrices back-to-back with out_ready tied to 1 → second out_valid exactly 10 cycles after the first.
